counter_cmd_seq: RTL and testbench

COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

---
 rtl/counter_seq_pkg.sv | 33 +++
 rtl/counter_cmd_seq_if.sv | 21 ++
 rtl/seq_cmd_fifo.sv | 64 ++++++
 rtl/counter_cmd_seq.sv | 136 +++++++++++++
 tb/tb_counter_cmd_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
package counter_seq_pkg;

  // Sequencer states: waiting for work, one-cycle counter load, counting.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // One queued command as stored in the FIFO.
  typedef struct packed {
    logic       init;
    logic [3:0] load;
    logic [1:0] ctrl;
    logic [3:0] len;
  } cmd_t;

  // Counting modes understood by the downstream counter.
  localparam logic [1:0] UP1 = 2'b00;
  localparam logic [1:0] UP2 = 2'b01;
  localparam logic [1:0] DN1 = 2'b10;
  localparam logic [1:0] DN2 = 2'b11;

  // Pack loose command fields into a cmd_t.
  function automatic cmd_t make_cmd(input logic       init,
                                    input logic [3:0] load,
                                    input logic [1:0] ctrl,
                                    input logic [3:0] len);
    return '{init: init, load: load, ctrl: ctrl, len: len};
  endfunction

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command channel into the sequencer: valid/ready handshake plus payload.
interface counter_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_init;
  logic [3:0] cmd_load;
  logic [1:0] cmd_ctrl;
  logic [3:0] cmd_len;

  // Command producer side.
  modport master (
    output cmd_valid, cmd_init, cmd_load, cmd_ctrl, cmd_len,
    input  cmd_ready
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_init, cmd_load, cmd_ctrl, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/seq_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), pointers wrap naturally,
// flush empties it in one edge and overrides push/pop.
module seq_cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     pop_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when the same edge pops.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array has no reset; occupancy is tracked by count, so stale
  // entries are never observed and the RAM stays a plain RAM.
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer for a load/count counter: queues commands and plays each
// one out as an optional one-cycle load followed by a len+1 cycle count phase.
module counter_cmd_seq
  import counter_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  counter_cmd_seq_if.slave       cmd,
  input  logic                   GAMEOVER,
  output logic                   INIT,
  output logic [3:0]             load,
  output logic [1:0]             CONTROL,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_t     state, state_d;
  cmd_t       head;
  cmd_t       push_data;
  logic [3:0] rem, rem_d;
  logic [3:0] cur_load, cur_load_d;
  logic [1:0] cur_ctrl, cur_ctrl_d;
  logic       init_d;
  logic [3:0] load_d;
  logic [1:0] control_d;
  logic       start;
  logic       push;
  logic       full;
  logic       empty;

  // No command is taken during reset or on a game-over edge.
  assign cmd.cmd_ready = !full && !GAMEOVER && !RST;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign push_data     = make_cmd(cmd.cmd_init, cmd.cmd_load, cmd.cmd_ctrl, cmd.cmd_len);
  assign busy          = (state != IDLE);

  seq_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (start),
    .pop_data  (head),
    .flush     (GAMEOVER),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // State, phase counter, current command and registered counter outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would let later lines see new ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rem      <= '0;
      cur_load <= '0;
      cur_ctrl <= UP1;
      INIT     <= 1'b0;
      load     <= '0;
      CONTROL  <= UP1;
    end else begin
      state    <= state_d;
      rem      <= rem_d;
      cur_load <= cur_load_d;
      cur_ctrl <= cur_ctrl_d;
      INIT     <= init_d;
      load     <= load_d;
      CONTROL  <= control_d;
    end
  end

  // Next-state and next-output decode; game-over overrides everything.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    rem_d      = rem;
    cur_load_d = cur_load;
    cur_ctrl_d = cur_ctrl;
    init_d     = 1'b0;
    load_d     = load;
    control_d  = CONTROL;
    start      = 1'b0;

    case (state)
      IDLE: start = !empty;
      LOAD: begin
        state_d   = RUN;
        load_d    = cur_load;
        control_d = cur_ctrl;
      end
      RUN: begin
        control_d = cur_ctrl;
        if (rem != 4'd0) begin
          rem_d = rem - 4'd1;
        end else if (!empty) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop the head entry and launch it with no idle gap.
    if (start) begin
      cur_load_d = head.load;
      cur_ctrl_d = head.ctrl;
      rem_d      = head.len;
      control_d  = head.ctrl;
      if (head.init) begin
        state_d = LOAD;
        init_d  = 1'b1;
        load_d  = head.load;
      end else begin
        state_d = RUN;
      end
    end

    // Abort: queue is flushed, current command dropped, outputs held.
    if (GAMEOVER) begin
      start      = 1'b0;
      state_d    = IDLE;
      rem_d      = '0;
      cur_load_d = cur_load;
      cur_ctrl_d = cur_ctrl;
      init_d     = 1'b0;
      load_d     = load;
      control_d  = CONTROL;
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq: a queue-and-schedule model
// predicts every output each cycle; directed cases add literal checks.
module tb_counter_cmd_seq;
  import counter_seq_pkg::*;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       GAMEOVER;
  logic       INIT;
  logic [3:0] load;
  logic [1:0] CONTROL;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  counter_cmd_seq_if bus();

  counter_cmd_seq #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd        (bus.slave),
    .GAMEOVER   (GAMEOVER),
    .INIT       (INIT),
    .load       (load),
    .CONTROL    (CONTROL),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted commands, plus a per-cycle schedule of the outputs the
  // command being executed must produce.
  typedef struct {
    bit         busy;
    bit         init;
    logic [3:0] load;
    logic [1:0] ctrl;
  } out_t;

  cmd_t       mq[$];
  out_t       sched[$];
  logic [3:0] last_load = '0;
  logic [1:0] last_ctrl = '0;
  bit         m_push;
  cmd_t       m_cmd;
  out_t       e;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      sched.delete();
      last_load = '0;
      last_ctrl = '0;
    end else if (GAMEOVER) begin
      mq.delete();
      sched.delete();
    end else begin
      m_push = bus.cmd_valid && (mq.size() < DEPTH);
      if (sched.size() > 0) void'(sched.pop_front());
      if (sched.size() == 0 && mq.size() > 0) begin
        m_cmd = mq.pop_front();
        if (m_cmd.init) begin
          last_load = m_cmd.load;
          sched.push_back('{1'b1, 1'b1, m_cmd.load, m_cmd.ctrl});
        end
        last_ctrl = m_cmd.ctrl;
        for (int i = 0; i <= int'(m_cmd.len); i++)
          sched.push_back('{1'b1, 1'b0, last_load, m_cmd.ctrl});
      end
      if (m_push)
        mq.push_back(make_cmd(bus.cmd_init, bus.cmd_load, bus.cmd_ctrl, bus.cmd_len));
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge CLK) begin
    if (sched.size() > 0) e = sched[0];
    else e = '{1'b0, 1'b0, last_load, last_ctrl};
    check("cmp_ready", bus.cmd_ready, (RST !== 1'b1) && (mq.size() < DEPTH) && !GAMEOVER);
    check("cmp_fifo_count", fifo_count, mq.size());
    check("cmp_busy", busy, e.busy);
    check("cmp_init", INIT, e.init);
    check("cmp_load", load, e.load);
    check("cmp_control", CONTROL, e.ctrl);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one command and hold it until accepted; returns edges waited.
  task automatic push_cmd(input logic i, input logic [3:0] l, input logic [1:0] c,
                          input logic [3:0] n, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_init  = i;
    bus.cmd_load  = l;
    bus.cmd_ctrl  = c;
    bus.cmd_len   = n;
    while (!acc && waited < 64) begin
      @(negedge CLK);
      acc = bus.cmd_ready;
      @(posedge CLK);
      #1;
      waited++;
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", acc, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_fifo_count", fifo_count, 3'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    RST           = 1'b1;
    GAMEOVER      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_init  = 1'b0;
    bus.cmd_load  = '0;
    bus.cmd_ctrl  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_init", INIT, 1'b0);
    check("rst_load", load, 4'd0);
    check("rst_control", CONTROL, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_ready", bus.cmd_ready, 1'b0);
    RST = 1'b0;
    #1;
    check("post_rst_ready", bus.cmd_ready, 1'b1);

    // Load 5, count up for 3 cycles, then idle.
    push_cmd(1'b1, 4'd5, UP1, 4'd2, w);
    check("t1_queued", fifo_count, 3'd1);
    check("t1_not_busy", busy, 1'b0);
    step();
    check("t1_init", INIT, 1'b1);
    check("t1_load", load, 4'd5);
    check("t1_busy_load", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_run_init", INIT, 1'b0);
      check("t1_run_ctrl", CONTROL, UP1);
      check("t1_run_busy", busy, 1'b1);
    end
    step();
    check("t1_idle", busy, 1'b0);

    // Back-to-back: 01 for one cycle then 11 for two, no gap.
    push_cmd(1'b0, 4'd0, UP2, 4'd0, w);
    push_cmd(1'b0, 4'd0, DN2, 4'd1, w);
    check("t2_ctrl_a", CONTROL, UP2);
    check("t2_busy_a", busy, 1'b1);
    step();
    check("t2_ctrl_b0", CONTROL, DN2);
    check("t2_busy_b0", busy, 1'b1);
    step();
    check("t2_ctrl_b1", CONTROL, DN2);
    check("t2_busy_b1", busy, 1'b1);
    step();
    check("t2_idle", busy, 1'b0);
    check("t2_ctrl_held", CONTROL, DN2);
    check("t2_load_held", load, 4'd5);

    // Fill the FIFO behind a long command; the fifth push waits.
    push_cmd(1'b0, 4'd0, UP1, 4'd15, w);
    step();
    push_cmd(1'b0, 4'd0, UP2, 4'd1, w);
    push_cmd(1'b1, 4'd7, DN1, 4'd2, w);
    push_cmd(1'b0, 4'd0, DN2, 4'd0, w);
    push_cmd(1'b0, 4'd0, UP1, 4'd3, w);
    check("t3_full_count", fifo_count, 3'd4);
    check("t3_full_ready", bus.cmd_ready, 1'b0);
    push_cmd(1'b1, 4'd12, DN2, 4'd1, w);
    check("t3_held_wait", (w > 1), 1'b1);
    wait_idle();
    check("t3_last_ctrl", CONTROL, DN2);
    check("t3_last_load", load, 4'd12);

    // Game-over while running with three queued.
    push_cmd(1'b0, 4'd0, UP2, 4'd15, w);
    step();
    push_cmd(1'b1, 4'd3, DN1, 4'd0, w);
    push_cmd(1'b0, 4'd0, UP1, 4'd1, w);
    push_cmd(1'b0, 4'd0, DN2, 4'd2, w);
    check("t4_queued", fifo_count, 3'd3);
    GAMEOVER = 1'b1;
    #1;
    check("t4_ready_pulse", bus.cmd_ready, 1'b0);
    @(posedge CLK);
    #1;
    GAMEOVER = 1'b0;
    check("t4_flushed", fifo_count, 3'd0);
    check("t4_idle", busy, 1'b0);
    check("t4_init", INIT, 1'b0);
    step();
    check("t4_stay_idle", busy, 1'b0);

    // Asynchronous reset mid-run, then a fresh command.
    push_cmd(1'b0, 4'd0, DN1, 4'd10, w);
    step();
    push_cmd(1'b1, 4'd6, UP2, 4'd0, w);
    #3;
    RST = 1'b1;
    #1;
    check("t5_rst_init", INIT, 1'b0);
    check("t5_rst_load", load, 4'd0);
    check("t5_rst_ctrl", CONTROL, 2'b00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_count", fifo_count, 3'd0);
    check("t5_rst_ready", bus.cmd_ready, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("t5_ready_after", bus.cmd_ready, 1'b1);
    push_cmd(1'b1, 4'd9, DN1, 4'd0, w);
    check("t5_first_edge", w, 1);
    step();
    check("t5_init", INIT, 1'b1);
    check("t5_load", load, 4'd9);
    step();
    check("t5_run_init", INIT, 1'b0);
    check("t5_run_ctrl", CONTROL, DN1);
    check("t5_run_busy", busy, 1'b1);
    step();
    check("t5_idle", busy, 1'b0);

    // Pointer wrap: ten single-cycle commands in a row.
    for (int i = 0; i < 10; i++)
      push_cmd(1'b0, 4'd0, 2'(i), 4'd0, w);
    wait_idle();
    check("t6_last_ctrl", CONTROL, 2'd1);
    check("t6_load_held", load, 4'd9);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
